pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central sequencer for the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
//  Drives each stage register's write_enable/flush pair plus the PC write enable.
//  Resolves load-use hazards, taken-branch redirects and multi-cycle data-memory waits.
//  Detects a memory timeout and reports it.
//  Sits beside the datapath in the CPU top; the stage-register wrappers take their hard-wired 1'b1/1'b0 from here.
// PARAMETERS
//  MEM_TIMEOUT  64  max consecutive MEM_WAIT cycles before entering HALT (>=1)
//  CNT_W        32  width of the performance counters
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      asynchronous, active-high reset
//  id_rs1         in   5      source reg 1 of instruction in ID
//  id_rs2         in   5      source reg 2 of instruction in ID
//  id_use_rs1     in   1      ID instruction reads rs1
//  id_use_rs2     in   1      ID instruction reads rs2
//  ex_rd          in   5      dest reg of instruction in EX
//  ex_mem_read    in   1      EX instruction is a load
//  ex_br_taken    in   1      EX resolved a taken branch/jump (redirect)
//  mem_req        in   1      MEM instruction accesses data memory
//  mem_ready      in   1      data memory completes access this cycle
//  pc_we          out  1      PC write enable
//  if_id_we       out  1      IF/ID write enable
//  if_id_flush    out  1      IF/ID load zeros
//  id_ex_we       out  1      ID/EX write enable
//  id_ex_flush    out  1      ID/EX load zeros
//  ex_mem_we      out  1      EX/MEM write enable
//  ex_mem_flush   out  1      EX/MEM load zeros
//  mem_wb_we      out  1      MEM/WB write enable
//  mem_wb_flush   out  1      MEM/WB load zeros
//  mem_timeout    out  1      sticky error: MEM_TIMEOUT exceeded
//  stall_cnt      out  CNT_W  cycles with pc_we=0 (saturating)
//  flush_cnt      out  CNT_W  taken-branch flush events (saturating)
// BEHAVIOUR
//  - Reset is asynchronous, active-high.
//    - State=RUN, wait counter=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
//    - While reset is high, all *_we=0 and all *_flush=0.
//  - Flush semantics: a register with we=1 and flush=1 loads all-zero (a bubble); flush is ignored when we=0.
//  - lu_hz = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  - mem_stall = mem_req & ~mem_ready.
//  - FSM states: RUN, MEM_WAIT, HALT. Outputs are combinational from state and inputs; there is no added latency.
//  - RUN, default: all we=1, all flush=0.
//  - RUN, priority 1, mem_stall:
//    - pc/if_id/id_ex/ex_mem we=0.
//    - mem_wb we=1, flush=1 (bubble into WB).
//    - Next state MEM_WAIT, wait counter <= 1.
//  - RUN, priority 2, ex_br_taken:
//    - all we=1; if_id_flush=1, id_ex_flush=1.
//    - flush_cnt++.
//    - lu_hz is ignored (the dependent instruction is wrong-path).
//  - RUN, priority 3, lu_hz:
//    - pc_we=0, if_id_we=0.
//    - id_ex we=1, flush=1 (one bubble).
//    - ex_mem and mem_wb advance.
//  - MEM_WAIT, mem_ready=0:
//    - Outputs are the same as the RUN mem_stall case.
//    - wait counter++.
//    - When the counter reaches MEM_TIMEOUT, next state is HALT.
//  - MEM_WAIT, mem_ready=1:
//    - Evaluate exactly as RUN priorities 2/3 (branch/load-use are held in EX/ID and re-resolve now).
//    - Next state RUN, counter <= 0.
//  - HALT:
//    - All we=0, mem_timeout=1.
//    - Exit only via reset.
//  - stall_cnt increments on every cycle with pc_we=0 and reset deasserted; it saturates at all-ones. flush_cnt saturates the same way.
//  - Simultaneous ex_br_taken and mem_stall: the stall wins and the branch flush is deferred to the release cycle (counted once).
//  - Reset asserted mid-MEM_WAIT or in HALT: immediate return to RUN with all counters cleared.
// TESTING
//  1. Load-use detection.
//     - Stimulus: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle.
//     - Required: pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1; stall_cnt 0->1.
//  2. Load-use to x0 is not a hazard.
//     - Stimulus: same as test 1 with ex_rd=0.
//     - Required: all we=1, no flush, stall_cnt unchanged.
//  3. Branch overrides load-use.
//     - Stimulus: ex_br_taken=1 together with the test 1 hazard.
//     - Required: all we=1, if_id_flush=id_ex_flush=1; flush_cnt=1.
//  4. Memory wait then release.
//     - Stimulus: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1.
//     - Required: 3 cycles of pc..ex_mem we=0 with mem_wb_flush=1; release cycle all we=1; state RUN; stall_cnt=3.
//  5. Memory timeout.
//     - Stimulus: MEM_TIMEOUT=4, mem_ready held 0.
//     - Required: HALT after 4 wait cycles, mem_timeout=1 and all we=0 permanently.
//     - Then: asserting reset asynchronously mid-cycle clears mem_timeout and both counters.
//  6. Deferred branch during memory stall.
//     - Stimulus: ex_br_taken=1 with mem_stall for 2 cycles, then mem_ready=1.
//     - Required: the flush appears only on the release cycle; flush_cnt=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//  Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers
//  and the PC. It resolves load-use hazards, taken-branch redirects and
//  multi-cycle data-memory waits, and it halts the pipeline on a memory timeout.
//
//  Ports
//   clk, reset                  rising-edge clock, asynchronous active-high reset
//   id_rs1/id_rs2, id_use_rs*   source registers of the ID instruction and their use flags
//   ex_rd, ex_mem_read          destination register of the EX instruction, and the
//                               flag that marks it as a load
//   ex_br_taken                 EX resolved a taken branch or jump
//   mem_req, mem_ready          data-memory access in MEM, and its completion
//   *_we / *_flush              write enable and zero-load for each stage register
//   pc_we                       PC write enable
//   mem_timeout                 sticky error flag, high while halted
//   stall_cnt, flush_cnt        saturating performance counters
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_flush,
  output logic             ex_mem_we,
  output logic             ex_mem_flush,
  output logic             mem_wb_we,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              lu_hz;
  logic              mem_stall;
  logic              hold;     // memory wait: freeze PC..EX/MEM, bubble into WB
  logic              resolve;  // pipeline is free to apply branch/load-use rules
  logic              br_event;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign lu_hz = ex_mem_read && (ex_rd != 5'd0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd)));
  assign mem_stall   = mem_req && !mem_ready;
  assign wait_nxt    = wait_cnt + WAIT_W'(1);
  assign mem_timeout = (state == HALT);

  // While waiting on memory, only mem_ready matters: the access is already in MEM.
  always_comb begin
    hold    = 1'b0;
    resolve = 1'b0;
    case (state)
      RUN:      begin hold = mem_stall;  resolve = !mem_stall; end
      MEM_WAIT: begin hold = !mem_ready; resolve = mem_ready;  end
      default:  begin hold = 1'b0;       resolve = 1'b0;       end
    endcase
  end

  // A branch pending under a stall is picked up on the release cycle, so it is
  // counted exactly once.
  assign br_event = !reset && resolve && ex_br_taken;

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_we     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_we    = 1'b1;
    ex_mem_flush = 1'b0;
    mem_wb_we    = 1'b1;
    mem_wb_flush = 1'b0;
    if (reset || state == HALT) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      mem_wb_we = 1'b0;
    end else if (hold) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_br_taken) begin
      // The load-use partner in ID is wrong-path, so it is squashed, not stalled.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu_hz) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_we)   stall_cnt <= sat_inc(stall_cnt);
      if (br_event) flush_cnt <= sat_inc(flush_cnt);
      case (state)
        RUN: begin
          if (mem_stall) begin
            wait_cnt <= WAIT_W'(1);
            state    <= (MEM_TIMEOUT <= 1) ? HALT : MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            state    <= RUN;
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt >= WAIT_W'(MEM_TIMEOUT)) state <= HALT;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//  Directed scenarios followed by randomized traffic, checked against a
//  reference model that tracks the length of the current memory stall and a
//  halted flag.
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 4;
  localparam int CW  = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0, ex_br_taken = 0;
  logic mem_req = 0, mem_ready = 0;
  logic pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
  logic ex_mem_we, ex_mem_flush, mem_wb_we, mem_wb_flush, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [8:0] obs_o;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush),
    .ex_mem_we(ex_mem_we), .ex_mem_flush(ex_mem_flush),
    .mem_wb_we(mem_wb_we), .mem_wb_flush(mem_wb_flush),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign obs_o = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
                  ex_mem_we, ex_mem_flush, mem_wb_we, mem_wb_flush};

  // Output patterns {pc, if_id we/flush, id_ex we/flush, ex_mem we/flush, mem_wb we/flush}
  localparam logic [8:0] O_NORM  = 9'b110101010;
  localparam logic [8:0] O_BR    = 9'b111111010;
  localparam logic [8:0] O_LU    = 9'b000111010;
  localparam logic [8:0] O_STALL = 9'b000000011;
  localparam logic [8:0] O_OFF   = 9'b000000000;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_len  = 0;    // consecutive memory-stall cycles so far
  bit m_halt = 0;
  int m_scnt = 0;
  int m_fcnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic bit m_stalled();
    if (m_len > 0) return !mem_ready;
    return mem_req && !mem_ready;
  endfunction

  function automatic bit m_lu();
    return ex_mem_read && ex_rd != 0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic logic [8:0] model_out();
    if (reset || m_halt) return O_OFF;
    if (m_stalled())     return O_STALL;
    if (ex_br_taken)     return O_BR;
    if (m_lu())          return O_LU;
    return O_NORM;
  endfunction

  task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit mr, input bit br, input bit req, input bit rdy);
    id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = 5'(rd); ex_mem_read = mr; ex_br_taken = br; mem_req = req; mem_ready = rdy;
  endtask

  // Called just after a falling edge with inputs applied; returns after the next falling edge.
  task automatic step();
    logic [8:0] e;
    bit st, br;
    #1;
    e  = model_out();
    st = m_stalled();
    br = ex_br_taken;
    chk("outputs", 32'(obs_o), 32'(e));
    chk("timeout_flag", 32'(mem_timeout), 32'(m_halt));
    @(posedge clk);
    if (reset) begin
      m_len = 0; m_halt = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (!e[8]) m_scnt = sat(m_scnt);
      if (!m_halt) begin
        if (br && !st) m_fcnt = sat(m_fcnt);
        if (st) begin
          m_len++;
          if (m_len >= TMO) m_halt = 1;
        end else begin
          m_len = 0;
        end
      end
    end
    #1;
    chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
    chk("timeout_after_edge", 32'(mem_timeout), 32'(m_halt));
    @(negedge clk);
  endtask

  // Asserts reset between clock edges and checks the asynchronous clear.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_outputs", 32'(obs_o), 32'(O_OFF));
    chk("rst_timeout", 32'(mem_timeout), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    m_len = 0; m_halt = 0; m_scnt = 0; m_fcnt = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    @(negedge clk);
    chk("init_outputs", 32'(obs_o), 32'(O_OFF));
    chk("init_timeout", 32'(mem_timeout), 32'd0);
    chk("init_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("init_flush_cnt", 32'(flush_cnt), 32'd0);
    reset = 1'b0;

    // Load-use hazard on rs1
    set_in(5, 0, 1, 0, 5, 1, 0, 0, 1);
    #1;
    chk("t1_pc_we", 32'(pc_we), 32'd0);
    chk("t1_if_id_we", 32'(if_id_we), 32'd0);
    chk("t1_id_ex_flush", 32'(id_ex_flush), 32'd1);
    chk("t1_ex_mem_we", 32'(ex_mem_we), 32'd1);
    step();
    chk("t1_stall_cnt", 32'(stall_cnt), 32'd1);

    // Load to x0 never creates a hazard
    set_in(0, 0, 1, 0, 0, 1, 0, 0, 1);
    #1;
    chk("t2_outputs", 32'(obs_o), 32'(O_NORM));
    step();
    chk("t2_stall_cnt", 32'(stall_cnt), 32'd1);

    // Branch wins over load-use
    set_in(5, 0, 1, 0, 5, 1, 1, 0, 1);
    #1;
    chk("t3_outputs", 32'(obs_o), 32'(O_BR));
    step();
    chk("t3_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("t3_stall_cnt", 32'(stall_cnt), 32'd1);

    // Memory wait of 3 cycles, then release
    async_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_wait_outputs", 32'(obs_o), 32'(O_STALL));
      step();
    end
    mem_ready = 1'b1;
    #1;
    chk("t4_release_outputs", 32'(obs_o), 32'(O_NORM));
    step();
    chk("t4_stall_cnt", 32'(stall_cnt), 32'd3);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t4_back_in_run", 32'(obs_o), 32'(O_NORM));
    step();

    // Branch held during a memory stall is applied on release
    async_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t6_wait_outputs", 32'(obs_o), 32'(O_STALL));
      step();
      chk("t6_no_flush_yet", 32'(flush_cnt), 32'd0);
    end
    mem_ready = 1'b1;
    #1;
    chk("t6_release_outputs", 32'(obs_o), 32'(O_BR));
    step();
    chk("t6_flush_cnt", 32'(flush_cnt), 32'd1);

    // Randomized traffic
    async_reset();
    for (int i = 0; i < 400; i++) begin
      set_in(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)),
             ($urandom_range(0, 3) != 0));
      step();
      if (m_halt || $urandom_range(0, 63) == 0) async_reset();
    end

    // Memory timeout, permanent halt, counter saturation, async clear
    async_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < TMO; i++) step();
    chk("t5_timeout", 32'(mem_timeout), 32'd1);
    chk("t5_halt_outputs", 32'(obs_o), 32'(O_OFF));
    set_in(3, 3, 1, 1, 3, 1, 1, 1, 1);
    for (int i = 0; i < 70; i++) step();
    chk("t5_still_halted", 32'(mem_timeout), 32'd1);
    chk("t5_stall_sat", 32'(stall_cnt), 32'(CMAX));
    async_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
